// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, optional parity, one or two stop bits,
// with a clear-to-send gate before each frame.
module uart_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic [7:0] usr_options,
    input  logic       cts_n,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int DIVISOR = CLK_FREQ / BAUD;
    localparam int CW      = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CTS,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [2:0]     idx, idx_n;
    logic [7:0]     data_q, data_n;
    logic [2:0]     opt_q, opt_n;
    logic           line_n;
    logic           busy_n;
    logic           done_n;
    logic           bit_end;
    logic           unused_opts;

    assign unused_opts = ^usr_options[7:3];
    assign bit_end     = (cnt == CW'(DIVISOR - 1));

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            data_q     <= '0;
            opt_q      <= '0;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            data_q     <= data_n;
            opt_q      <= opt_n;
            serial_out <= line_n;
            tx_busy    <= busy_n;
            tx_done    <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        data_n  = data_q;
        opt_n   = opt_q;
        busy_n  = tx_busy;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (tx_start) begin
                    data_n  = tx_data;
                    opt_n   = usr_options[2:0];
                    busy_n  = 1'b1;
                    state_n = WAIT_CTS;
                end
            end
            WAIT_CTS: begin
                cnt_n = '0;
                if (!cts_n) begin
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx == 3'd7) begin
                        idx_n   = '0;
                        state_n = opt_q[0] ? PARITY : STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = STOP;
                end
            end
            STOP: begin
                // idx counts stop bits so two-stop frames reuse the same state
                if (bit_end) begin
                    cnt_n = '0;
                    if (opt_q[2] && idx == 3'd0) begin
                        idx_n = 3'd1;
                    end else begin
                        idx_n   = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // line level is registered from the next state so it tracks state exactly
    always_comb begin
        line_n = 1'b1;
        unique case (state_n)
            START:   line_n = 1'b0;
            DATA:    line_n = data_q[idx_n];
            PARITY:  line_n = (^data_q) ^ opt_q[1];
            default: line_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIVISOR=16: frame shape, parity,
// stop bits, CTS gating, ignored restarts and mid-frame reset.
module tb_uart_tx;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] usr_options;
    logic       cts_n;
    logic       serial_out;
    logic       tx_busy;
    logic       tx_done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    uart_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .usr_options (usr_options),
        .cts_n       (cts_n),
        .serial_out  (serial_out),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (tx_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] o);
        tx_data     = d;
        usr_options = o;
        tx_start    = 1'b1;
        @(negedge sys_clk);
        tx_start    = 1'b0;
    endtask

    task automatic run_frame(input int nbits, output logic [15:0] bits,
                             output int lat, output int dn);
        bits = '0;
        lat  = 0;
        dn   = -1;
        while (serial_out === 1'b1 && lat < 300) begin
            @(negedge sys_clk);
            lat++;
        end
        if (serial_out !== 1'b0) begin
            chk("start_timeout", {31'b0, serial_out}, 32'd0);
            return;
        end
        for (int n = 0; n < 400; n++) begin
            if (n % 16 == 8 && n / 16 < nbits) bits[n/16] = serial_out;
            if (tx_done === 1'b1) begin
                dn = n;
                break;
            end
            @(negedge sys_clk);
        end
    endtask

    logic [15:0] bits;
    int          lat;
    int          dn;
    int          d0;
    int          errs;

    initial begin
        reset       = 1'b1;
        tx_data     = '0;
        tx_start    = 1'b0;
        usr_options = '0;
        cts_n       = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_line", {31'b0, serial_out}, 32'd1);
        chk("rst_busy", {31'b0, tx_busy}, 32'd0);
        chk("rst_done", {31'b0, tx_done}, 32'd0);
        reset = 1'b0;
        @(negedge sys_clk);

        send(8'h55, 8'h00);
        chk("busy_on", {31'b0, tx_busy}, 32'd1);
        run_frame(10, bits, lat, dn);
        chk("f55_lat", lat, 32'd1);
        chk("f55_bits", {16'b0, bits}, 32'h02AA);
        chk("f55_len", dn, 32'd160);
        chk("f55_busy_end", {31'b0, tx_busy}, 32'd0);

        // issued in the tx_done cycle: back-to-back frame
        send(8'h07, 8'h01);
        run_frame(11, bits, lat, dn);
        chk("b2b_lat", lat, 32'd1);
        chk("par_even_bits", {16'b0, bits}, 32'h060E);
        chk("par_even_len", dn, 32'd176);

        send(8'h07, 8'h03);
        run_frame(11, bits, lat, dn);
        chk("par_odd_bits", {16'b0, bits}, 32'h040E);
        chk("par_odd_len", dn, 32'd176);

        send(8'hA3, 8'h04);
        run_frame(11, bits, lat, dn);
        chk("stop2_bits", {16'b0, bits}, 32'h0746);
        chk("stop2_len", dn, 32'd176);
        repeat (3) @(negedge sys_clk);

        cts_n = 1'b1;
        send(8'h3C, 8'h00);
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            if (serial_out !== 1'b1 || tx_busy !== 1'b1) errs++;
            @(negedge sys_clk);
        end
        chk("cts_hold", errs, 32'd0);
        cts_n = 1'b0;
        @(negedge sys_clk);
        chk("cts_start", {31'b0, serial_out}, 32'd0);
        run_frame(10, bits, lat, dn);
        chk("cts_lat", lat, 32'd0);
        chk("cts_bits", {16'b0, bits}, 32'h0278);
        chk("cts_len", dn, 32'd160);
        repeat (3) @(negedge sys_clk);

        d0 = done_cnt;
        send(8'h55, 8'h00);
        fork
            run_frame(10, bits, lat, dn);
            begin
                repeat (40) @(negedge sys_clk);
                tx_data  = 8'hFF;
                tx_start = 1'b1;
                cts_n    = 1'b1;
                @(negedge sys_clk);
                tx_start = 1'b0;
            end
        join
        chk("ign_bits", {16'b0, bits}, 32'h02AA);
        chk("ign_len", dn, 32'd160);
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (serial_out !== 1'b1 || tx_busy !== 1'b0) errs++;
        end
        chk("ign_idle", errs, 32'd0);
        chk("ign_done_cnt", done_cnt - d0, 32'd1);
        cts_n = 1'b0;

        d0 = done_cnt;
        send(8'h55, 8'h00);
        lat = 0;
        while (serial_out === 1'b1 && lat < 300) begin
            @(negedge sys_clk);
            lat++;
        end
        repeat (70) @(negedge sys_clk);
        chk("mid_bit3", {31'b0, serial_out}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_line", {31'b0, serial_out}, 32'd1);
        chk("mid_rst_busy", {31'b0, tx_busy}, 32'd0);
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;
        chk("mid_rst_nodone", done_cnt - d0, 32'd0);
        send(8'h55, 8'h00);
        run_frame(10, bits, lat, dn);
        chk("post_rst_lat", lat, 32'd1);
        chk("post_rst_bits", {16'b0, bits}, 32'h02AA);
        chk("post_rst_len", dn, 32'd160);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 50000000, giving the system clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD, default 9600, giving the line bit rate; DIVISOR = CLK_FREQ/BAUD (integer, at least 2).
REQ-003 Port sys_clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  reset, asynchronous, active-high.
REQ-005 Port tx_data  input  8  byte to send, sampled on an accepted tx_start.
REQ-006 Port tx_start  input  1  send request, one-cycle pulse.
REQ-007 Port usr_options  input  8  frame format: bit0 parity enable; bit1 parity odd(1)/even(0); bit2 two stop bits(1)/one(0); bits7:3 ignored.
REQ-008 Port cts_n  input  1  remote clear-to-send, active-low, already synchronised to sys_clk.
REQ-009 Port serial_out  output  1  RS-232 TX line at logic level, idle high.
REQ-010 Port tx_busy  output  1  high from the cycle after an accepted tx_start until the cycle tx_done is asserted.
REQ-011 Port tx_done  output  1  one-cycle pulse in the cycle after the final stop-bit period ends.

Function
REQ-012 The block SHALL implement states IDLE, WAIT_CTS, START, DATA, PARITY and STOP.
REQ-013 A tx_start in IDLE SHALL be accepted: latch tx_data and usr_options[2:0], and move to WAIT_CTS next cycle.
REQ-014 A tx_start outside IDLE SHALL be ignored; latched data and options SHALL NOT change.
REQ-015 WAIT_CTS SHALL move to START on the first cycle in which cts_n is 0, and SHALL hold serial_out high while waiting.
REQ-016 cts_n SHALL be checked only in WAIT_CTS; deasserting it mid-frame SHALL NOT pause the frame.
REQ-017 Each bit period SHALL last exactly DIVISOR cycles, timed by a counter that clears on every state entry.
REQ-018 START SHALL drive serial_out 0 for one bit period.
REQ-019 DATA SHALL shift out 8 bits LSB first, using a 3-bit index, one bit period each.
REQ-020 PARITY SHALL be entered only when option bit0 is 1.
REQ-021 In PARITY, serial_out SHALL be the XOR of the 8 data bits, inverted when option bit1 is 1 (odd parity).
REQ-022 STOP SHALL drive serial_out 1 for one bit period, or for two when option bit2 is 1.
REQ-023 At the end of STOP the block SHALL pulse tx_done, clear tx_busy, and return to IDLE.
REQ-024 A tx_start in the cycle tx_done is high SHALL be accepted, giving back-to-back frames with no extra idle bit.
REQ-025 Total frame length SHALL be (10 + P + S) x DIVISOR cycles after START entry, where P = option bit0 and S = option bit2.
REQ-026 serial_out SHALL come directly from a flip-flop, with no combinational glitches.

Reset
REQ-027 While reset is high: state IDLE, serial_out 1, tx_busy 0, tx_done 0, counters 0, latches 0.
REQ-028 Assertion of reset mid-frame SHALL abort the frame immediately (asynchronously), with no tx_done pulse.
REQ-029 After reset deasserts, the block SHALL accept a tx_start on the first rising edge.

Verification (CLK_FREQ=16, BAUD=1, DIVISOR=16)
REQ-030 tx_data=0x55, options=0x00, cts_n=0, pulse tx_start -> serial_out 0,1,0,1,0,1,0,1,0,1, each bit held 16 cycles; tx_done pulses 160 cycles after START entry; tx_busy then 0.
REQ-031 tx_data=0x07, options=0x01 -> parity bit 1; repeat with options=0x03 -> parity bit 0; each frame is 176 cycles.
REQ-032 options=0x04, tx_data=0xA3 -> frame is 0,1,1,0,0,0,1,0,1,1,1, with the stop level held 32 cycles.
REQ-033 cts_n=1, pulse tx_start, wait 100 cycles with serial_out steady 1, then set cts_n=0 -> START entered the following cycle.
REQ-034 A second tx_start with 0xFF issued mid-frame -> it is ignored, the original byte completes, and only one tx_done occurs.
REQ-035 Assert reset during DATA bit 3 -> serial_out is 1 in the same cycle, tx_busy is 0, and there is no tx_done; a fresh 0x55 frame then transmits correctly.
